// File: rtl/codec_config_seq.sv
// codec_config_seq: power-up register writer for a WM8731-class codec.
// One 3-byte I2C write per table entry, retried on NACK or timeout.
module codec_config_seq #(
  parameter logic [6:0] DEV_ADDR     = 7'h1A,
  parameter int         POWERUP_WAIT = 12000,
  parameter int         GAP_CYCLES   = 120,
  parameter int         TIMEOUT      = 4095,
  parameter int         MAX_RETRY    = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_restart,
  output logic       o_i2c_start,
  output logic [6:0] o_i2c_dev_addr,
  output logic [7:0] o_i2c_byte0,
  output logic [7:0] o_i2c_byte1,
  input  logic       i_i2c_busy,
  input  logic       i_i2c_done,
  input  logic       i_i2c_nack,
  output logic [3:0] o_entry_idx,
  output logic       o_config_done,
  output logic       o_config_err
);

  localparam logic [3:0]  LAST_IDX  = 4'd11;
  localparam logic [15:0] PW_LAST   = 16'(POWERUP_WAIT - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_ISSUE,
    S_WAIT_DONE,
    S_FAIL,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [3:0]  idx;
  logic [3:0]  idx_n;
  logic [2:0]  retry;
  logic [2:0]  retry_n;
  logic        ok;
  logic        ok_n;
  logic        start;
  logic [15:0] entry;
  logic [7:0]  b0_q;
  logic [7:0]  b1_q;
  logic        done_q;
  logic        err_q;

  // Each entry packs {reg_addr[6:0], reg_data[8:0]}, which is
  // exactly {byte0, byte1} on the wire.
  function automatic logic [15:0] tbl_entry(input logic [3:0] i);
    logic [15:0] e;
    e = '0;
    unique case (i)
      4'd0:    e = {7'd15, 9'h000};
      4'd1:    e = {7'd6,  9'h010};
      4'd2:    e = {7'd0,  9'h017};
      4'd3:    e = {7'd1,  9'h017};
      4'd4:    e = {7'd2,  9'h079};
      4'd5:    e = {7'd3,  9'h079};
      4'd6:    e = {7'd4,  9'h012};
      4'd7:    e = {7'd5,  9'h000};
      4'd8:    e = {7'd7,  9'h00A};
      4'd9:    e = {7'd8,  9'h001};
      4'd10:   e = {7'd9,  9'h001};
      4'd11:   e = {7'd6,  9'h000};
      default: e = '0;
    endcase
    return e;
  endfunction

  // Bytes follow the index that will be current next cycle, so they
  // settle together with o_entry_idx and hold for the whole write.
  assign entry = tbl_entry(idx_n);

  // Next-state, counter, index and retry bookkeeping.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    retry_n = retry;
    ok_n    = ok;
    start   = 1'b0;
    unique case (state)
      S_PWR_WAIT: begin
        if (cnt == PW_LAST) begin
          state_n = S_ISSUE;
          cnt_n   = '0;
          idx_n   = '0;
          retry_n = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_ISSUE: begin
        if (!i_i2c_busy) begin
          start   = 1'b1;
          cnt_n   = '0;
          state_n = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_i2c_done) begin
          ok_n    = !i_i2c_nack;
          cnt_n   = '0;
          state_n = i_i2c_nack ? S_FAIL : S_GAP;
        end else if (cnt == TO_LAST) begin
          cnt_n   = '0;
          state_n = S_FAIL;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_FAIL: begin
        ok_n = 1'b0;
        if (retry < RETRY_MAX) begin
          retry_n = retry + 3'd1;
          cnt_n   = '0;
          state_n = S_GAP;
        end else begin
          state_n = S_ERROR;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (!ok) begin
            state_n = S_ISSUE;
          end else if (idx == LAST_IDX) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + 4'd1;
            retry_n = '0;
            state_n = S_ISSUE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_DONE, S_ERROR: begin
        if (i_restart) begin
          state_n = S_ISSUE;
          cnt_n   = '0;
          idx_n   = '0;
          retry_n = '0;
        end
      end
      default: begin
        state_n = S_PWR_WAIT;
        cnt_n   = '0;
      end
    endcase
  end

  // State and registered outputs; done/err track the state entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_PWR_WAIT;
      cnt    <= '0;
      idx    <= '0;
      retry  <= '0;
      ok     <= 1'b0;
      b0_q   <= '0;
      b1_q   <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      retry  <= retry_n;
      ok     <= ok_n;
      b0_q   <= entry[15:8];
      b1_q   <= entry[7:0];
      done_q <= (state_n == S_DONE);
      err_q  <= (state_n == S_ERROR);
    end
  end

  assign o_i2c_start    = start;
  assign o_i2c_dev_addr = DEV_ADDR;
  assign o_i2c_byte0    = b0_q;
  assign o_i2c_byte1    = b1_q;
  assign o_entry_idx    = idx;
  assign o_config_done  = done_q;
  assign o_config_err   = err_q;

endmodule

// File: tb/tb_codec_config_seq.sv
// tb_codec_config_seq: randomized I2C responder plus an
// entry/attempt-level model of the expected write sequence.
module tb_codec_config_seq;

  localparam int PW  = 12000;
  localparam int GAP = 120;
  localparam int TO  = 4095;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       slave_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       busy;
  logic       i2c_done = 1'b0;
  logic       i2c_nack = 1'b0;
  logic       start;
  logic [6:0] dev;
  logic [7:0] b0;
  logic [7:0] b1;
  logic [3:0] idx;
  logic       cfg_done;
  logic       cfg_err;

  assign busy = slave_busy | hold_busy;

  codec_config_seq dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_restart      (restart),
    .o_i2c_start    (start),
    .o_i2c_dev_addr (dev),
    .o_i2c_byte0    (b0),
    .o_i2c_byte1    (b1),
    .i_i2c_busy     (busy),
    .i_i2c_done     (i2c_done),
    .i_i2c_nack     (i2c_nack),
    .o_entry_idx    (idx),
    .o_config_done  (cfg_done),
    .o_config_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [15:0] bytes;
    logic [3:0]  idx;
  } st_t;

  int          cyc;
  st_t         log_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] tbl[12];
  int          nack_plan[12];
  bit          hang[12];
  int          att[12];
  int          hold_entry = -1;
  int          release_cyc = -1;
  bit          exp_err;
  int          exp_idx;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Cycle counter: cycle k is the k-th rising edge after reset release.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  // Log every start request seen mid-cycle.
  always @(negedge clk)
    if (rst_n && start)
      log_q.push_back('{c: cyc, bytes: {b0, b1}, idx: idx});

  // I2C master model: NACKs the first nack_plan[e] attempts of entry e,
  // never answers a hung entry, optionally stalls busy after one entry.
  initial begin
    int e;
    int a;
    forever begin
      @(negedge clk);
      if (rst_n && start) begin
        e = int'(idx);
        a = att[e];
        att[e]++;
        if (!hang[e]) begin
          @(posedge clk);
          #1 slave_busy = 1'b1;
          repeat ($urandom_range(20, 60)) @(posedge clk);
          #1;
          i2c_done = 1'b1;
          i2c_nack = (a < nack_plan[e]);
          @(posedge clk);
          #1;
          if (e == hold_entry && !i2c_nack) hold_busy = 1'b1;
          i2c_done   = 1'b0;
          i2c_nack   = 1'b0;
          slave_busy = 1'b0;
          if (hold_busy) begin
            repeat (200) @(posedge clk);
            #1;
            release_cyc = cyc;
            hold_busy   = 1'b0;
            hold_entry  = -1;
          end
        end
      end
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 12; i++) begin
      nack_plan[i] = 0;
      hang[i]      = 1'b0;
      att[i]       = 0;
    end
    log_q.delete();
  endtask

  // Expected writes: each entry is tried until ACKed, at most 4 times.
  task automatic build_model();
    int fails;
    int tries;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 11;
    for (int e = 0; e < 12; e++) begin
      fails = hang[e] ? 4 : nack_plan[e];
      tries = (fails >= 4) ? 4 : fails + 1;
      for (int t = 0; t < tries; t++) exp_q.push_back(tbl[e]);
      if (fails >= 4) begin
        exp_err = 1'b1;
        exp_idx = e;
        break;
      end
    end
  endtask

  task automatic run_and_check(input string nm, input bit mid_rs);
    int k;
    int n;
    k = 0;
    while (!cfg_done && !cfg_err && k < 40000) begin
      @(posedge clk);
      #1;
      restart = 1'b0;
      k++;
      if (mid_rs && log_q.size() > 0 && !cfg_done && !cfg_err
          && $urandom_range(0, 499) == 0)
        restart = 1'b1;
    end
    restart = 1'b0;
    chk({nm, "_end"}, int'(k < 40000), 1);
    repeat (400) @(posedge clk);
    #1;
    chk({nm, "_nwr"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_wr%0d", nm, i), int'(log_q[i].bytes), int'(exp_q[i]));
    chk({nm, "_done"}, int'(cfg_done), int'(!exp_err));
    chk({nm, "_err"}, int'(cfg_err), int'(exp_err));
    chk({nm, "_idx"}, int'(idx), exp_idx);
  endtask

  task automatic do_restart(output int rc);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    rc = cyc;
    chk("rs_drop", int'({cfg_done, cfg_err}), 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_start"}, int'(start), 0);
    chk({nm, "_bytes"}, int'({b0, b1}), 0);
    chk({nm, "_idx0"}, int'(idx), 0);
    chk({nm, "_flags"}, int'({cfg_done, cfg_err}), 0);
    chk({nm, "_dev"}, int'(dev), 'h1A);
  endtask

  initial begin
    int rc;
    int d;
    int k;
    tbl = '{16'h1E00, 16'h0C10, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
            16'h0812, 16'h0A00, 16'h0E0A, 16'h1001, 16'h1201, 16'h0C00};
    clear_plan();

    repeat (3) @(posedge clk);
    #3;
    chk_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    hold_entry = 3;
    build_model();
    run_and_check("s1", 1'b0);
    if (log_q.size() > 4) begin
      chk("pwr_first", int'(log_q[0].c >= PW - 1 && log_q[0].c <= PW + 1), 1);
      chk("busy_start", log_q[4].c, release_cyc);
    end else begin
      chk("s1_short", log_q.size(), 12);
    end

    clear_plan();
    nack_plan[4] = 2;
    build_model();
    do_restart(rc);
    run_and_check("s2", 1'b1);
    if (log_q.size() > 0) chk("s2_nowait", int'(log_q[0].c - rc <= 2), 1);

    clear_plan();
    nack_plan[2] = 4;
    build_model();
    do_restart(rc);
    run_and_check("s3", 1'b0);

    for (int r = 0; r < 3; r++) begin
      clear_plan();
      for (int e = 0; e < 12; e++)
        nack_plan[e] = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 4);
      build_model();
      do_restart(rc);
      run_and_check($sformatf("r%0d", r), 1'b1);
    end

    clear_plan();
    hang[0] = 1'b1;
    build_model();
    do_restart(rc);
    run_and_check("s5", 1'b0);
    if (log_q.size() >= 4) begin
      for (int i = 1; i < 4; i++) begin
        d = log_q[i].c - log_q[i - 1].c;
        chk($sformatf("to_gap%0d", i), int'(d >= TO + GAP && d <= TO + GAP + 4), 1);
      end
    end

    clear_plan();
    hang[0] = 1'b1;
    do_restart(rc);
    k = 0;
    while (log_q.size() == 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("s6_first", int'(log_q.size() > 0), 1);
    repeat (100) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    repeat (2) @(posedge clk);
    clear_plan();
    build_model();
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("s6", 1'b0);
    if (log_q.size() > 0)
      chk("s6_pwr", int'(log_q[0].c >= PW - 1 && log_q[0].c <= PW + 1), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
